// File: rtl/lights_pkg.sv
// lights_pkg
// Shared definitions for the LED lighting path.
//   PWM_MAX     : last pwm_cnt value of a period (255 steps: 0..254)
//   WHITE       : full-scale colour word
//   pwm_state_t : driver FSM states
//   *_LSB       : bit position of each 8-bit colour field in the 24-bit word
package lights_pkg;

  localparam logic [7:0]  PWM_MAX = 8'd254;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_t;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if
// Bundles the colour request and the LED drive side of rgb_pwm_driver.
//   enable       : level run request (no handshake; sampled every clock)
//   light        : 24-bit colour word, only sampled when shadows load
//   led_r/g/b    : PWM drive outputs
//   period_start : first cycle of each PWM period
//   busy         : driver not idle
//   dbg_state    : current FSM state
//   dbg_pwm_cnt  : current PWM step counter
// modport master : colour source / bench side
// modport slave  : driver side
interface rgb_pwm_driver_if;
  import lights_pkg::*;

  logic        enable;
  logic [23:0] light;
  logic        led_r;
  logic        led_g;
  logic        led_b;
  logic        period_start;
  logic        busy;
  pwm_state_t  dbg_state;
  logic [7:0]  dbg_pwm_cnt;

  modport master (
    output enable, light,
    input  led_r, led_g, led_b, period_start, busy, dbg_state, dbg_pwm_cnt
  );

  modport slave (
    input  enable, light,
    output led_r, led_g, led_b, period_start, busy, dbg_state, dbg_pwm_cnt
  );

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel
// One colour channel: 8-bit shadow duty register plus registered compare.
//   clk, rst    : clock, async active-low reset
//   load        : copy duty_in into the shadow this cycle
//   active_next : driver will be non-idle next cycle
//   duty_in     : colour field from the light word
//   pwm_next    : PWM counter value for next cycle
//   led         : registered PWM output
module pwm_channel
  import lights_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       active_next,
  input  logic [7:0] duty_in,
  input  logic [7:0] pwm_next,
  output logic       led
);

  logic [7:0] duty;
  logic [7:0] duty_next;

  // The compare uses next-cycle counter and duty so the registered LED lines
  // up with the counter value it is shown alongside.
  assign duty_next = load ? duty_in : duty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty <= 8'd0;
      led  <= 1'b0;
    end else begin
      duty <= duty_next;
      led  <= active_next && (pwm_next < duty_next);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
// Turns a 24-bit colour word into three PWM LED drives. Duties are latched
// once per PWM period; dropping enable drains the current period first.
//   PRESCALE : clock cycles per PWM step (>= 1)
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   bus      : rgb_pwm_driver_if.slave (enable/light in, LEDs/status out)
module rgb_pwm_driver
  import lights_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst,
  rgb_pwm_driver_if.slave    bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_STOP = STOP;

  logic [1:0]       state, state_n;
  logic [PRE_W-1:0] pre_cnt, pre_n;
  logic [7:0]       pwm_cnt, pwm_n;
  logic             tick, wrap, load, active_n;
  logic             ps_q;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == PWM_MAX);

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    pwm_n   = pwm_cnt;
    load    = 1'b0;
    if (state == ST_IDLE) begin
      pre_n = '0;
      pwm_n = 8'd0;
      if (bus.enable) begin
        state_n = ST_RUN;
        load    = 1'b1;
      end
    end else begin
      pre_n = tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_n = wrap ? 8'd0 : pwm_cnt + 8'd1;
      case (state)
        ST_RUN: begin
          // A wrap always reloads, even if enable falls on that same cycle;
          // the following STOP then drains one full period.
          if (wrap) load = 1'b1;
          if (!bus.enable) state_n = ST_STOP;
        end
        ST_STOP: begin
          if (bus.enable) begin
            // Resume without touching the counters.
            state_n = ST_RUN;
            if (wrap) load = 1'b1;
          end else if (wrap) begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign active_n = (state_n != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
      ps_q    <= 1'b0;
    end else begin
      state   <= state_n;
      pre_cnt <= pre_n;
      pwm_cnt <= pwm_n;
      ps_q    <= active_n && (pwm_n == 8'd0) && (pre_n == '0);
    end
  end

  pwm_channel u_ch_r (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .active_next (active_n),
    .duty_in     (bus.light[R_LSB +: 8]),
    .pwm_next    (pwm_n),
    .led         (bus.led_r)
  );

  pwm_channel u_ch_g (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .active_next (active_n),
    .duty_in     (bus.light[G_LSB +: 8]),
    .pwm_next    (pwm_n),
    .led         (bus.led_g)
  );

  pwm_channel u_ch_b (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .active_next (active_n),
    .duty_in     (bus.light[B_LSB +: 8]),
    .pwm_next    (pwm_n),
    .led         (bus.led_b)
  );

  assign bus.period_start = ps_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.dbg_state    = pwm_state_t'(state);
  assign bus.dbg_pwm_cnt  = pwm_cnt;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver
// Directed bench: instance a runs with PRESCALE=1, instance b with PRESCALE=4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rgb_pwm_driver;
  import lights_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rgb_pwm_driver_if bus_a ();
  rgb_pwm_driver_if bus_b ();

  rgb_pwm_driver #(.PRESCALE(1)) dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_a.slave)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int p_a   = 0;  // expected pwm_cnt of instance a in the next sampled cycle

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic r, input logic g, input logic b,
                       input logic ps, input logic bsy, input logic [7:0] pwm);
    chk({tag, "_r"},    32'(bus_a.led_r),        32'(r));
    chk({tag, "_g"},    32'(bus_a.led_g),        32'(g));
    chk({tag, "_b"},    32'(bus_a.led_b),        32'(b));
    chk({tag, "_ps"},   32'(bus_a.period_start), 32'(ps));
    chk({tag, "_busy"}, 32'(bus_a.busy),         32'(bsy));
    chk({tag, "_pwm"},  32'(bus_a.dbg_pwm_cnt),  32'(pwm));
  endtask

  // ---------------- driver tasks ----------------
  // Check n running cycles of instance a with the given duties.
  task automatic run_a(input string tag, input int n,
                       input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_a(tag, (p_a < 32'(dr)), (p_a < 32'(dg)), (p_a < 32'(db)), (p_a == 0), 1'b1, 8'(p_a));
      p_a = (p_a == 254) ? 0 : p_a + 1;
    end
  endtask

  task automatic idle_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_a(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    bus_a.enable = 1'b0;
    bus_a.light  = 24'h0;
    bus_b.enable = 1'b0;
    bus_b.light  = 24'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_a("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst_b_busy", 32'(bus_b.busy), 32'd0);
    chk("rst_b_r",    32'(bus_b.led_r), 32'd0);
    rst_n = 1'b1;
    idle_a("idle_after_rst", 3);

    // Duty accuracy: R=255, G=0, B=128, two periods
    bus_a.light  = 24'hFF0080;
    bus_a.enable = 1'b1;
    p_a = 0;
    run_a("duty", 510, 8'hFF, 8'h00, 8'h80);

    // Drain: drop enable while pwm_cnt=50, busy through 254, then idle
    run_a("drain_pre", 51, 8'hFF, 8'h00, 8'h80);
    bus_a.enable = 1'b0;
    run_a("drain", 204, 8'hFF, 8'h00, 8'h80);
    idle_a("drain_idle", 3);

    // Cancel: drop at 50, reassert at 100, counter keeps going
    bus_a.enable = 1'b1;
    p_a = 0;
    run_a("cancel_pre", 51, 8'hFF, 8'h00, 8'h80);
    bus_a.enable = 1'b0;
    run_a("cancel_stop", 50, 8'hFF, 8'h00, 8'h80);
    bus_a.enable = 1'b1;
    run_a("cancel_resume", 154, 8'hFF, 8'h00, 8'h80);
    run_a("cancel_next", 30, 8'hFF, 8'h00, 8'h80);

    // Shadow latching: light=0 lands at next period; white at pwm_cnt=100
    // must wait for the following period
    bus_a.light = 24'h000000;
    run_a("shadow_old", 225, 8'hFF, 8'h00, 8'h80);
    run_a("shadow_zero", 101, 8'h00, 8'h00, 8'h00);
    bus_a.light = WHITE;
    run_a("shadow_hold", 154, 8'h00, 8'h00, 8'h00);

    // White held across three periods: never drops at the wraps
    run_a("white", 765, 8'hFF, 8'hFF, 8'hFF);

    // Reset mid-run at pwm_cnt=40: outputs clear before any clock edge
    run_a("pre_reset", 41, 8'hFF, 8'hFF, 8'hFF);
    #2;
    rst_n        = 1'b0;
    bus_a.enable = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_a("post_rst", 5);

    // Prescaler: PRESCALE=4, duty 1 -> 4 cycles high per 1020-cycle period
    bus_b.light  = 24'h010101;
    bus_b.enable = 1'b1;
    for (int c = 0; c < 2040; c++) begin
      int m;
      @(negedge clk);
      m = c % 1020;
      chk("pre_r",    32'(bus_b.led_r),        32'(m < 4));
      chk("pre_g",    32'(bus_b.led_g),        32'(m < 4));
      chk("pre_b",    32'(bus_b.led_b),        32'(m < 4));
      chk("pre_ps",   32'(bus_b.period_start), 32'(m == 0));
      chk("pre_busy", 32'(bus_b.busy),         32'd1);
      chk("pre_pwm",  32'(bus_b.dbg_pwm_cnt),  32'(m / 4));
    end
    // Instance a stayed idle meanwhile
    chk_a("a_still_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
